// File: rtl/ifu_axi_fetch.sv
// rtl/ifu_axi_fetch.sv - instruction-fetch AXI4 single-beat read master
//
// Owns the PC and issues one 32-bit read per instruction. Each fetched word
// is handed to the IDU over a valid/ready handshake. Redirects may arrive at
// any time; a read already on the bus always completes and its data is
// dropped.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   - a fetch address with [1:0]!=0 is never issued; an error
//               instruction (inst=0, inst_err=1) is presented instead.
//   undefined - the address is issued unchanged.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   redirect_valid, redirect_pc     redirect pulse and new fetch PC
//   inst_valid/inst_ready           IDU handshake
//   inst, inst_pc, inst_err         fetched word, its PC, bus/alignment error
//   arvalid/arready, araddr, arid,
//   arlen, arsize, arburst          AXI read-address channel
//   rvalid/rready, rdata, rresp,
//   rlast, rid                      AXI read-data channel (rlast/rid ignored)

module ifu_axi_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter logic [3:0]  AXI_ID   = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ar_addr, w_ar_addr_nxt;
  logic        r_discard, w_discard_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_inst_err, w_inst_err_nxt;

  // Start a new fetch at w_fetch_addr this cycle.
  logic        w_fetch;
  logic [31:0] w_fetch_addr;

  logic        w_unused;
  assign w_unused = ^{rlast, rid, rresp[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ar_addr  <= RESET_PC;
      r_discard  <= 1'b0;
      r_inst     <= 32'd0;
      r_inst_pc  <= RESET_PC;
      r_inst_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ar_addr  <= w_ar_addr_nxt;
      r_discard  <= w_discard_nxt;
      r_inst     <= w_inst_nxt;
      r_inst_pc  <= w_inst_pc_nxt;
      r_inst_err <= w_inst_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ar_addr_nxt  = r_ar_addr;
    w_discard_nxt  = r_discard;
    w_inst_nxt     = r_inst;
    w_inst_pc_nxt  = r_inst_pc;
    w_inst_err_nxt = r_inst_err;
    w_fetch        = 1'b0;
    w_fetch_addr   = r_pc;

    case (r_state)
      S_IDLE: begin
        w_fetch      = 1'b1;
        w_fetch_addr = redirect_valid ? redirect_pc : r_pc;
      end
      S_AR: begin
        // Address must stay stable on the bus; remember to drop the data.
        if (redirect_valid) w_discard_nxt = 1'b1;
        if (arready) w_state_nxt = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (r_discard) begin
            // pc already holds the redirect target (or a newer one).
            w_discard_nxt = 1'b0;
            w_fetch       = 1'b1;
            w_fetch_addr  = redirect_valid ? redirect_pc : r_pc;
          end else if (redirect_valid) begin
            w_fetch      = 1'b1;
            w_fetch_addr = redirect_pc;
          end else begin
            w_inst_nxt     = rdata;
            w_inst_pc_nxt  = r_ar_addr;
            w_inst_err_nxt = rresp[1];
            w_state_nxt    = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_discard_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_fetch      = 1'b1;
          w_fetch_addr = redirect_pc;
        end else if (inst_ready) begin
          w_pc_nxt     = r_pc + 32'd4;
          w_fetch      = 1'b1;
          w_fetch_addr = r_pc + 32'd4;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (redirect_valid) w_pc_nxt = redirect_pc;

    if (w_fetch) begin
      w_ar_addr_nxt = w_fetch_addr;
`ifdef IFU_MISALIGN_CHECK_EN
      if (w_fetch_addr[1:0] != 2'b00) begin
        w_state_nxt    = S_HOLD;
        w_inst_nxt     = 32'd0;
        w_inst_err_nxt = 1'b1;
        w_inst_pc_nxt  = w_fetch_addr;
      end else begin
        w_state_nxt = S_AR;
      end
`else
      w_state_nxt = S_AR;
`endif
    end
  end

  assign arvalid    = (r_state == S_AR);
  assign rready     = (r_state == S_R);
  assign inst_valid = (r_state == S_HOLD);
  assign araddr     = r_ar_addr;
  assign arid       = AXI_ID;
  assign arlen      = 8'd0;
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_err   = r_inst_err;

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb/tb_ifu_axi_fetch.sv - self-checking bench for ifu_axi_fetch

module tb_ifu_axi_fetch;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;

  // Reference model: the address the next issued fetch must carry.
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifu_axi_fetch #(.RESET_PC(RST_PC), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait (bounded) until arvalid is high, then check the address.
  task automatic wait_ar();
    int n = 0;
    while (arvalid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("arvalid_seen", {31'd0, arvalid}, 32'd1);
    chk("araddr", araddr, exp_pc);
  endtask

  // Complete AR handshake after ard wait cycles; leaves DUT in R.
  task automatic do_ar(input int ard);
    wait_ar();
    repeat (ard) begin
      cyc();
      chk("ar_hold_addr", araddr, exp_pc);
      chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
    end
    arready = 1'b1; cyc(); arready = 1'b0;
    chk("rready_after_ar", {31'd0, rready}, 32'd1);
    chk("no_arvalid_in_r", {31'd0, arvalid}, 32'd0);
  endtask

  // One complete fetch: AR, R, HOLD for hold cycles, then accept.
  task automatic fetch(input int ard, input int rd, input logic [31:0] data,
                       input logic [1:0] resp, input int hold);
    logic [31:0] this_pc;
    this_pc = exp_pc;
    do_ar(ard);
    repeat (rd) cyc();
    rvalid = 1'b1; rdata = data; rresp = resp; cyc(); rvalid = 1'b0;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("inst", inst, data);
    chk("inst_pc", inst_pc, this_pc);
    chk("inst_err", {31'd0, inst_err}, {31'd0, resp[1]});
    repeat (hold) begin
      cyc();
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, data);
      chk("hold_pc", inst_pc, this_pc);
      chk("hold_no_ar", {31'd0, arvalid}, 32'd0);
    end
    inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    exp_pc = this_pc + 32'd4;
    chk("accept_drop_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    inst_ready = 1'b0; arready = 1'b0; rvalid = 1'b0;
    rdata = 32'd0; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
    exp_pc = RST_PC;

    // Reset state
    repeat (2) cyc();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk("rst_araddr", araddr, RST_PC);
    rst_n = 1'b1;
    cyc();
    chk("first_arvalid", {31'd0, arvalid}, 32'd1);
    chk("ar_consts", {13'd0, arid, arlen, arsize, arburst}, {13'd0, 4'd0, 8'd0, 3'b010, 2'b01});

    // Zero-wait fetch, then hold 5 cycles
    fetch(0, 0, 32'h0000_0413, 2'b00, 5);
    chk("after_accept_ar", {31'd0, arvalid}, 32'd1);
    chk("next_addr", araddr, 32'h3000_0004);

    // Redirect in the 2nd AR cycle of a 4-cycle arready delay
    wait_ar();
    cyc();
    pulse_redirect(32'h8000_0000); cyc(); redirect_valid = 1'b0;
    chk("ar_redir_stable", araddr, 32'h3000_0004);
    repeat (2) begin cyc(); chk("ar_redir_stable2", araddr, 32'h3000_0004); end
    arready = 1'b1; cyc(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1111_1111; cyc(); rvalid = 1'b0;
    chk("discard_no_valid", {31'd0, inst_valid}, 32'd0);
    exp_pc = 32'h8000_0000;
    wait_ar();

    // Redirect together with rvalid
    do_ar(0);
    rvalid = 1'b1; rdata = 32'h2222_2222; pulse_redirect(32'h8000_0100);
    cyc(); rvalid = 1'b0; redirect_valid = 1'b0;
    chk("redir_rvalid_no_valid", {31'd0, inst_valid}, 32'd0);
    exp_pc = 32'h8000_0100;
    wait_ar();

    // Redirect together with inst_ready in HOLD
    do_ar(0);
    rvalid = 1'b1; rdata = 32'h3333_3333; cyc(); rvalid = 1'b0;
    chk("hold_before_redir", {31'd0, inst_valid}, 32'd1);
    inst_ready = 1'b1; pulse_redirect(32'h8000_0100);
    cyc(); inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("redir_ready_no_valid", {31'd0, inst_valid}, 32'd0);
    wait_ar();

    // Error responses
    fetch(0, 1, 32'hDEAD_BEEF, 2'b10, 0);
    fetch(1, 0, 32'hCAFE_0001, 2'b01, 1);

    // Randomized fetches with occasional HOLD redirects
    for (int i = 0; i < 30; i++) begin
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        do_ar(0);
        rvalid = 1'b1; rdata = $urandom; cyc(); rvalid = 1'b0;
        exp_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        pulse_redirect(exp_pc); cyc(); redirect_valid = 1'b0;
        chk("rand_redir_drop", {31'd0, inst_valid}, 32'd0);
      end
    end

    // Asynchronous reset while in R
    do_ar(0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rready", {31'd0, rready}, 32'd0);
    chk("async_rst_arvalid", {31'd0, arvalid}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    exp_pc = RST_PC;
    wait_ar();
    fetch(0, 0, 32'h0000_0013, 2'b00, 0);

    // Misaligned redirect
    do_ar(0);
    rvalid = 1'b1; rdata = 32'h4444_4444; cyc(); rvalid = 1'b0;
    pulse_redirect(32'h8000_0002); cyc(); redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_no_ar", {31'd0, arvalid}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_err", {31'd0, inst_err}, 32'd1);
    chk("mis_pc", inst_pc, 32'h8000_0002);
    chk("mis_inst", inst, 32'd0);
`else
    chk("mis_ar", {31'd0, arvalid}, 32'd1);
    chk("mis_addr", araddr, 32'h8000_0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
